// File: rtl/minmax_frame_ctrl_if.sv
// minmax_frame_ctrl_if: sample-in and result-out handshake bundle for minmax_frame_ctrl
//   in_valid, in_data, in_ready          : sample stream, producer -> controller
//   res_valid, res_ready, min_out, max_out : result stream, controller -> consumer
//   master modport is the producer/consumer side, slave modport is the controller
interface minmax_frame_ctrl_if #(parameter int DATA_W = 32) ();
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] min_out;
   logic [DATA_W-1:0] max_out;
   modport master (output in_valid, in_data, res_ready, input in_ready, res_valid, min_out, max_out);
   modport slave (input in_valid, in_data, res_ready, output in_ready, res_valid, min_out, max_out);
endinterface

// File: rtl/minmax_frame_ctrl.sv
// minmax_frame_ctrl: framed, back-pressured signed running min/max over a sample stream
//   clk, rst          : clock and synchronous active-high reset
//   start, frame_len  : begin a frame of frame_len samples (IDLE only, frame_len != 0)
//   abort             : cancel the frame in progress (COLLECT only)
//   bus (slave)       : sample valid/ready input and min/max result valid/ready output
//   busy, sample_cnt  : frame in progress, samples accepted so far
module minmax_frame_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] frame_len,
   input  logic             abort,
   minmax_frame_ctrl_if.slave bus,
   output logic             busy,
   output logic [CNT_W-1:0] sample_cnt
);
   typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;
   state_t            state, next_state;
   logic [CNT_W-1:0]  len;
   logic [DATA_W-1:0] min_r, max_r;
   logic              go, accept, last;
   always_comb begin
      go         = state == IDLE && start && frame_len != '0;
      // abort wins over a coincident sample, so that sample is never taken
      accept     = state == COLLECT && bus.in_valid && !abort;
      last       = accept && sample_cnt + CNT_W'(1) == len;
      next_state = state;
      case (state)
         IDLE:    next_state = go ? COLLECT : IDLE;
         COLLECT: next_state = abort ? IDLE : last ? REPORT : COLLECT;
         REPORT:  next_state = bus.res_ready ? IDLE : REPORT;
         default: next_state = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         len        <= '0;
         sample_cnt <= '0;
         min_r      <= '0;
         max_r      <= '0;
      end else begin
         state <= next_state;
         if (go) begin
            len        <= frame_len;
            sample_cnt <= '0;
         end
         if (state == COLLECT && abort) sample_cnt <= '0;
         // first sample of a frame seeds both trackers; min/max otherwise keep the last result
         if (accept) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            min_r <= (sample_cnt == '0 || $signed(bus.in_data) < $signed(min_r)) ? bus.in_data : min_r;
            max_r <= (sample_cnt == '0 || $signed(bus.in_data) > $signed(max_r)) ? bus.in_data : max_r;
         end
      end
   end
   assign bus.in_ready  = state == COLLECT;
   assign bus.res_valid = state == REPORT;
   assign bus.min_out   = min_r;
   assign bus.max_out   = max_r;
   assign busy          = state != IDLE;
endmodule

// File: tb/tb_minmax_frame_ctrl.sv
// tb_minmax_frame_ctrl: directed per-cycle vector table plus hand sequences for minmax_frame_ctrl
module tb_minmax_frame_ctrl;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;
   localparam int NV     = 26;
   typedef struct {
      logic              rst, start, abort, iv, rr;
      logic [CNT_W-1:0]  len;
      logic [DATA_W-1:0] d;
      logic              ir, rv, b;
      logic [DATA_W-1:0] mn, mx;
      logic [CNT_W-1:0]  cnt;
   } vec_t;
   logic             clk = 1'b0;
   logic             rst, start, abort, busy;
   logic [CNT_W-1:0] frame_len, sample_cnt;
   int               n_chk = 0;
   int               n_fail = 0;
   vec_t             v [NV];
   minmax_frame_ctrl_if #(.DATA_W(DATA_W)) bus ();
   minmax_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .abort(abort),
      .bus(bus), .busy(busy), .sample_cnt(sample_cnt)
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(input int r, s, l, a, iv, input logic [DATA_W-1:0] d,
                               input int rr, ir, rv, b, input logic [DATA_W-1:0] mn, mx, input int c);
      vec_t t;
      t.rst = r[0]; t.start = s[0]; t.len = l[CNT_W-1:0]; t.abort = a[0]; t.iv = iv[0];
      t.d = d; t.rr = rr[0]; t.ir = ir[0]; t.rv = rv[0]; t.b = b[0];
      t.mn = mn; t.mx = mx; t.cnt = c[CNT_W-1:0];
      return t;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic expect_out(input string tag, input int ir, rv, b, input logic [DATA_W-1:0] mn, mx, input int c);
      chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(ir[0]));
      chk({tag, " res_valid"}, 32'(bus.res_valid), 32'(rv[0]));
      chk({tag, " busy"}, 32'(busy), 32'(b[0]));
      chk({tag, " min_out"}, bus.min_out, mn);
      chk({tag, " max_out"}, bus.max_out, mx);
      chk({tag, " sample_cnt"}, 32'(sample_cnt), 32'(c[CNT_W-1:0]));
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in();
      rst = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b0;
   endtask
   initial begin
      logic [DATA_W-1:0] smp [4];
      logic [DATA_W-1:0] emn [4];
      logic [DATA_W-1:0] emx [4];
      smp = '{32'd1, 32'd2, 32'hFFFFFFFF, 32'd4};
      emn = '{32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
      emx = '{32'd1, 32'd2, 32'd2, 32'd4};
      //        rst st len ab iv data          rr  ir rv b  min           max           cnt
      v[0]  = mk(1, 0, 0, 0, 0, 32'd0,        0,  0, 0, 0, 32'd0,        32'd0,        0);
      v[1]  = mk(0, 1, 4, 0, 0, 32'd0,        0,  1, 0, 1, 32'd0,        32'd0,        0);
      v[2]  = mk(0, 0, 0, 0, 1, 32'd1,        0,  1, 0, 1, 32'd1,        32'd1,        1);
      v[3]  = mk(0, 0, 0, 0, 1, 32'd2,        0,  1, 0, 1, 32'd1,        32'd2,        2);
      v[4]  = mk(0, 0, 0, 0, 1, 32'hFFFFFFFF, 0,  1, 0, 1, 32'hFFFFFFFF, 32'd2,        3);
      v[5]  = mk(0, 0, 0, 0, 1, 32'd4,        0,  0, 1, 1, 32'hFFFFFFFF, 32'd4,        4);
      v[6]  = mk(0, 0, 0, 0, 0, 32'd0,        1,  0, 0, 0, 32'hFFFFFFFF, 32'd4,        4);
      v[7]  = mk(0, 1, 3, 0, 0, 32'd0,        0,  1, 0, 1, 32'hFFFFFFFF, 32'd4,        0);
      v[8]  = mk(0, 0, 0, 0, 1, 32'h7FFFFFFF, 0,  1, 0, 1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1);
      v[9]  = mk(0, 0, 0, 0, 1, 32'h80000000, 0,  1, 0, 1, 32'h80000000, 32'h7FFFFFFF, 2);
      v[10] = mk(0, 0, 0, 0, 1, 32'd0,        0,  0, 1, 1, 32'h80000000, 32'h7FFFFFFF, 3);
      v[11] = mk(0, 0, 0, 0, 0, 32'd0,        1,  0, 0, 0, 32'h80000000, 32'h7FFFFFFF, 3);
      v[12] = mk(0, 1, 1, 0, 0, 32'd0,        0,  1, 0, 1, 32'h80000000, 32'h7FFFFFFF, 0);
      v[13] = mk(0, 0, 0, 0, 1, 32'd5,        0,  0, 1, 1, 32'd5,        32'd5,        1);
      v[14] = mk(0, 0, 0, 0, 0, 32'd0,        1,  0, 0, 0, 32'd5,        32'd5,        1);
      v[15] = mk(0, 1, 0, 0, 0, 32'd0,        0,  0, 0, 0, 32'd5,        32'd5,        1);
      v[16] = mk(0, 0, 0, 0, 1, 32'd9,        0,  0, 0, 0, 32'd5,        32'd5,        1);
      v[17] = mk(0, 1, 4, 0, 0, 32'd0,        0,  1, 0, 1, 32'd5,        32'd5,        0);
      v[18] = mk(0, 0, 0, 0, 1, 32'd10,       0,  1, 0, 1, 32'd10,       32'd10,       1);
      v[19] = mk(0, 0, 0, 0, 1, 32'd20,       0,  1, 0, 1, 32'd10,       32'd20,       2);
      v[20] = mk(0, 0, 0, 1, 1, 32'hFFFFFFCE, 0,  0, 0, 0, 32'd10,       32'd20,       0);
      v[21] = mk(0, 0, 0, 0, 1, 32'd99,       0,  0, 0, 0, 32'd10,       32'd20,       0);
      v[22] = mk(0, 1, 2, 0, 0, 32'd0,        0,  1, 0, 1, 32'd10,       32'd20,       0);
      v[23] = mk(0, 0, 0, 0, 1, 32'd7,        0,  1, 0, 1, 32'd7,        32'd7,        1);
      v[24] = mk(0, 0, 0, 0, 1, 32'd3,        0,  0, 1, 1, 32'd3,        32'd7,        2);
      v[25] = mk(0, 0, 0, 0, 0, 32'd0,        1,  0, 0, 0, 32'd3,        32'd7,        2);
      idle_in();
      for (int i = 0; i < NV; i++) begin
         rst = v[i].rst; start = v[i].start; frame_len = v[i].len; abort = v[i].abort;
         bus.in_valid = v[i].iv; bus.in_data = v[i].d; bus.res_ready = v[i].rr;
         tick();
         expect_out($sformatf("vec%0d", i), int'(v[i].ir), int'(v[i].rv), int'(v[i].b), v[i].mn, v[i].mx, int'(v[i].cnt));
      end
      // gapped producer with stray start pulses, then a back-pressured consumer with stray start/abort
      idle_in();
      start = 1'b1; frame_len = 16'd4;
      tick();
      start = 1'b0;
      expect_out("gap start", 1, 0, 1, 32'd3, 32'd7, 0);
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1; bus.in_data = smp[k];
         tick();
         bus.in_valid = 1'b0;
         if (k < 3) begin
            expect_out($sformatf("gap s%0d", k), 1, 0, 1, emn[k], emx[k], k + 1);
            for (int g = 0; g < 2; g++) begin
               start = 1'b1; frame_len = 16'd9;
               tick();
               start = 1'b0;
               expect_out($sformatf("gap s%0d idle%0d", k, g), 1, 0, 1, emn[k], emx[k], k + 1);
            end
         end else begin
            expect_out("gap last", 0, 1, 1, emn[k], emx[k], 4);
         end
      end
      for (int h = 0; h < 5; h++) begin
         start = 1'b1; frame_len = 16'd2; abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'd100;
         tick();
         expect_out($sformatf("hold%0d", h), 0, 1, 1, 32'hFFFFFFFF, 32'd4, 4);
      end
      idle_in();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      expect_out("handshake", 0, 0, 0, 32'hFFFFFFFF, 32'd4, 4);
      // quickest turnaround: start in the cycle after the handshake, sample the cycle after that
      start = 1'b1; frame_len = 16'd1;
      tick();
      start = 1'b0;
      expect_out("turn start", 1, 0, 1, 32'hFFFFFFFF, 32'd4, 0);
      bus.in_valid = 1'b1; bus.in_data = 32'd8;
      tick();
      bus.in_valid = 1'b0;
      expect_out("turn report", 0, 1, 1, 32'd8, 32'd8, 1);
      // reset raised between edges only acts at the next edge
      @(negedge clk);
      rst = 1'b1;
      #1;
      expect_out("rst pre-edge", 0, 1, 1, 32'd8, 32'd8, 1);
      tick();
      rst = 1'b0;
      expect_out("rst report", 0, 0, 0, 32'd0, 32'd0, 0);
      // reset in the middle of collecting
      start = 1'b1; frame_len = 16'd4;
      tick();
      start = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 32'hFFFFFFFD;
      tick();
      bus.in_data = 32'd6;
      tick();
      expect_out("rst mid pre", 1, 0, 1, 32'hFFFFFFFD, 32'd6, 2);
      rst = 1'b1; bus.in_data = 32'd50;
      tick();
      rst = 1'b0; bus.in_valid = 1'b0;
      expect_out("rst collect", 0, 0, 0, 32'd0, 32'd0, 0);
      tick();
      expect_out("rst idle", 0, 0, 0, 32'd0, 32'd0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/minmax_frame_ctrl.md
Name: minmax_frame_ctrl

Overview:
Frame-level controller and datapath that sequences signed running-min/max tracking over a stream of samples. On a start command it latches a frame length and accepts exactly that many samples over a valid/ready handshake. It then presents the frame's signed minimum and maximum over a result valid/ready handshake. It sits between a sample producer and the min/max consumer, replacing free-running tracking with framed, back-pressured operation.

Parameters:
DATA_W, 32, sample and result width (two's-complement signed)
CNT_W, 16, width of frame length and sample counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a frame; sampled only in IDLE
frame_len  in  CNT_W  samples per frame; latched on accepted start
abort  in  1  cancel the current frame; honoured only in COLLECT
in_valid  in  1  producer has a sample
in_data  in  DATA_W  signed sample
in_ready  out  1  controller accepts a sample this cycle
res_valid  out  1  min_out and max_out hold a completed frame result
res_ready  in  1  consumer takes the result
min_out  out  DATA_W  signed minimum of the frame
max_out  out  DATA_W  signed maximum of the frame
busy  out  1  high in COLLECT and REPORT
sample_cnt  out  CNT_W  samples accepted in the current frame

Behaviour:
- Reset: on any clock edge with rst=1, the state becomes IDLE and min_out, max_out, sample_cnt and the latched length are cleared to 0. res_valid, in_ready and busy are 0. rst overrides every other input, including mid-frame and mid-REPORT; any partial result is discarded.
- All outputs are registered or decoded from the state register only. There are no combinational paths from in_valid or res_ready to outputs.
- FSM states are IDLE, COLLECT and REPORT.
- IDLE:
  - in_ready=0, res_valid=0, busy=0.
  - start=1 with frame_len!=0: latch frame_len, clear sample_cnt, go to COLLECT.
  - start=1 with frame_len=0: ignored, stay in IDLE.
- COLLECT:
  - in_ready=1, busy=1.
  - A sample is accepted on a cycle with in_valid=1 and in_ready=1.
  - First sample (sample_cnt=0): min_out and max_out are both loaded with in_data.
  - Later samples: min_out is replaced if in_data < min_out, and max_out if in_data > max_out. Both comparisons are signed, so 32'hFFFFFFFF (-1) < 1 and 32'h80000000 is the most negative value. Equal values leave the registers unchanged.
  - sample_cnt increments on each accepted sample.
  - When the accepted sample is number frame_len (sample_cnt+1 equals the latched length), go to REPORT on the same edge.
  - If abort=1, go to IDLE, clear sample_cnt, and leave min_out/max_out at their partial values with res_valid kept at 0. abort takes priority over a simultaneous sample, which is not accepted.
  - start is ignored in this state.
- REPORT:
  - res_valid=1, in_ready=0, busy=1.
  - min_out, max_out and sample_cnt are held stable while res_ready=0, for any number of cycles.
  - res_valid=1 and res_ready=1 on the same cycle: go to IDLE, and res_valid falls on the next cycle.
  - start and abort are ignored in this state.
- Latency: res_valid rises in the cycle directly after the edge that accepts the last sample. Throughput is one sample per cycle in COLLECT.
- Frame turnaround: after REPORT→IDLE, start is sampled in IDLE. The earliest first sample of the next frame is 2 cycles after the result handshake.
- min_out and max_out retain the last frame's result in IDLE until the next frame's first sample is accepted.
- sample_cnt does not wrap. The maximum frame length is 2^CNT_W−1.

Test Plan:
- Basic frame: frame_len=4, samples 1, 2, -1, 4 back-to-back → res_valid high in the cycle after the 4th accept, min_out=32'hFFFFFFFF, max_out=4, sample_cnt=4.
- Producer gaps and consumer back-pressure: same samples with in_valid low for 2 cycles between each; res_ready held low for 5 cycles → result and res_valid stay stable throughout. res_valid drops the cycle after res_ready=1, and state is IDLE.
- Extremes and edge lengths:
  - frame_len=3, samples 32'h7FFFFFFF, 32'h80000000, 0 → min=32'h80000000, max=32'h7FFFFFFF.
  - frame_len=1, sample 5 → min=max=5.
  - start with frame_len=0 → busy stays 0.
- Abort: frame_len=4, abort after 2 samples, asserted together with in_valid → state IDLE, sample_cnt=0, res_valid never rises, third sample not accepted. A following frame of 7, 3 (frame_len=2) reports min=3, max=7.
- Synchronous reset mid-operation: rst=1 for one cycle during COLLECT (after 2 samples), and again during REPORT → next cycle all outputs are 0 and state is IDLE. rst asserted between clock edges has no effect until the next edge.
- Ignored commands: start pulsed during COLLECT and REPORT, and abort during REPORT → no change in state, outputs or latched length.
